// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU control codes, opcodes,
// FSM state encoding and the default datapath width.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_MUL = 3'b101,
    ALU_DIV = 3'b110
  } alu_ctrl_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_BEQ   = 4'b0010;
  localparam logic [3:0] OP_BNE   = 4'b0011;
  localparam logic [3:0] OP_SLTI  = 4'b0100;
  localparam logic [3:0] OP_ANDI  = 4'b0101;
  localparam logic [3:0] OP_ORI   = 4'b0110;

  localparam logic [2:0] FUNCT_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decoder: ALU control code, operand-B source,
// branch classification and illegal-instruction flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [2:0] funct,
  output alu_ctrl_e  ctrl,
  output logic       use_imm,
  output logic       is_branch,
  output logic       branch_ne,
  output logic       illegal
);

  always_comb begin
    ctrl      = ALU_ADD;
    use_imm   = 1'b0;
    is_branch = 1'b0;
    branch_ne = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_ILLEGAL) begin
          illegal = 1'b1;
        end else begin
          ctrl = alu_ctrl_e'(funct);
        end
      end
      OP_ADDI: begin
        ctrl    = ALU_ADD;
        use_imm = 1'b1;
      end
      OP_BEQ: begin
        ctrl      = ALU_SUB;
        is_branch = 1'b1;
      end
      OP_BNE: begin
        ctrl      = ALU_SUB;
        is_branch = 1'b1;
        branch_ne = 1'b1;
      end
      OP_SLTI: begin
        ctrl    = ALU_SLT;
        use_imm = 1'b1;
      end
      OP_ANDI: begin
        ctrl    = ALU_AND;
        use_imm = 1'b1;
      end
      OP_ORI: begin
        ctrl    = ALU_OR;
        use_imm = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: accepts one decoded request, drives the
// combinational ALU for one cycle, and returns the captured result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter bit          CHECK_DIV0 = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [2:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_imm,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_taken,
  output logic             rsp_err
);

  issue_state_e     state_q, state_d;
  alu_ctrl_e        alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             is_branch_q, is_branch_d;
  logic             branch_ne_q, branch_ne_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_taken_q, rsp_taken_d;
  logic             rsp_err_q, rsp_err_d;

  alu_ctrl_e        dec_ctrl;
  logic             dec_use_imm;
  logic             dec_is_branch;
  logic             dec_branch_ne;
  logic             dec_illegal;
  logic [WIDTH-1:0] b_sel;
  logic             div0;
  logic             res_zero;

  alu_op_decode u_decode (
    .op        (req_op),
    .funct     (req_funct),
    .ctrl      (dec_ctrl),
    .use_imm   (dec_use_imm),
    .is_branch (dec_is_branch),
    .branch_ne (dec_branch_ne),
    .illegal   (dec_illegal)
  );

  assign b_sel    = dec_use_imm ? req_imm : req_b;
  assign div0     = CHECK_DIV0 && (dec_ctrl == ALU_DIV) && (b_sel == '0);
  assign res_zero = (alu_result == '0);

  always_comb begin
    state_d      = state_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    is_branch_d  = is_branch_q;
    branch_ne_d  = branch_ne_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_taken_d  = rsp_taken_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // Rejected requests never touch alu_* so the ALU inputs stay quiet.
          if (dec_illegal || div0) begin
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_taken_d  = 1'b0;
            rsp_err_d    = 1'b1;
            state_d      = ST_RESP;
          end else begin
            alu_ctrl_d  = dec_ctrl;
            alu_a_d     = req_a;
            alu_b_d     = b_sel;
            is_branch_d = dec_is_branch;
            branch_ne_d = dec_branch_ne;
            state_d     = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = res_zero;
        rsp_taken_d  = is_branch_q && (branch_ne_q ? !res_zero : res_zero);
        rsp_err_d    = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      alu_ctrl_q   <= ALU_ADD;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      is_branch_q  <= 1'b0;
      branch_ne_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_taken_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      is_branch_q  <= is_branch_d;
      branch_ne_q  <= branch_ne_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_taken_q  <= rsp_taken_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Gated by reset so no request can be accepted while reset is held.
  assign req_ready  = (state_q == ST_IDLE) && !reset;
  assign rsp_valid  = (state_q == ST_RESP);
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_taken  = rsp_taken_q;
  assign rsp_err    = rsp_err_q;

endmodule
